// File: rtl/redmule_z_drain_buffer.sv
// Ping-pong result buffer: the array fills one tile bank column by column while the
// streamer drains the other bank row by row. Optional byte strobes: REDMULE_ZBUF_STRB_EN.
//
// state | meaning
// IDLE  | no full bank at drain_ptr, z_valid_o low
// DRAIN | presenting row row_cnt of bank drain_ptr, z_valid_o high
module redmule_z_drain_buffer #(
  parameter int unsigned DW    = 288,
  parameter int unsigned BITW  = 16,
  parameter int unsigned Width = 12,
  localparam int unsigned COLS = DW / BITW,
  localparam int unsigned CW   = $clog2(COLS),
  localparam int unsigned CLW  = CW + 1,
  localparam int unsigned RW   = $clog2(Width),
  localparam int unsigned RLW  = RW + 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic [Width-1:0][BITW-1:0]  z_i,
  input  logic                        z_valid_i,
  output logic                        z_ready_o,
  input  logic [CLW-1:0]              cols_lftovr_i,
  input  logic [RLW-1:0]              rows_lftovr_i,
  output logic [DW-1:0]               z_o,
  output logic                        z_valid_o,
  input  logic                        z_ready_i,
`ifdef REDMULE_ZBUF_STRB_EN
  output logic [DW/8-1:0]             z_strb_o,
`endif
  output logic                        full_o,
  output logic                        empty_o
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t         r_state;
  logic           r_z_valid;
  logic           r_fill_ptr;
  logic           r_drain_ptr;
  logic [CW-1:0]  r_col_cnt;
  logic [RW-1:0]  r_row_cnt;
  logic [1:0]     r_full;
  logic [CLW-1:0] r_col_lim [2];
  logic [RLW-1:0] r_row_lim [2];
  logic [BITW-1:0] r_bank [2][Width][COLS];

  logic           w_cap;
  logic           w_cap_last;
  logic           w_hs;
  logic           w_drain_last;
  logic           w_drain_ptr_nxt;
  logic [1:0]     w_full_nxt;
  logic [CLW-1:0] w_cols_in;
  logic [RLW-1:0] w_rows_in;
  logic [CLW-1:0] w_cap_lim;

  assign z_ready_o = ~r_full[r_fill_ptr];
  assign z_valid_o = r_z_valid;
  assign full_o    = r_full[0] & r_full[1];
  assign empty_o   = ~r_full[0] & ~r_full[1];

  assign w_cols_in = (cols_lftovr_i == '0) ? CLW'(COLS) : cols_lftovr_i;
  assign w_rows_in = (rows_lftovr_i == '0) ? RLW'(Width) : rows_lftovr_i;

  // Limits are latched on the first column of a tile; later columns use the stored ones.
  assign w_cap_lim  = (r_col_cnt == '0) ? w_cols_in : r_col_lim[r_fill_ptr];
  assign w_cap      = z_valid_i & z_ready_o;
  assign w_cap_last = w_cap & ({1'b0, r_col_cnt} == w_cap_lim - 1'b1);

  assign w_hs         = r_z_valid & z_ready_i;
  assign w_drain_last = w_hs & ({1'b0, r_row_cnt} == r_row_lim[r_drain_ptr] - 1'b1);
  assign w_drain_ptr_nxt = r_drain_ptr ^ w_drain_last;

  // Fill and drain always target different banks, so set and clear never collide.
  always_comb begin
    w_full_nxt = r_full;
    if (w_cap_last)   w_full_nxt[r_fill_ptr]  = 1'b1;
    if (w_drain_last) w_full_nxt[r_drain_ptr] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_z_valid    <= 1'b0;
      r_fill_ptr   <= 1'b0;
      r_drain_ptr  <= 1'b0;
      r_col_cnt    <= '0;
      r_row_cnt    <= '0;
      r_full       <= '0;
      r_col_lim[0] <= CLW'(COLS);
      r_col_lim[1] <= CLW'(COLS);
      r_row_lim[0] <= RLW'(Width);
      r_row_lim[1] <= RLW'(Width);
    end else if (clear_i) begin
      r_state     <= IDLE;
      r_z_valid   <= 1'b0;
      r_fill_ptr  <= 1'b0;
      r_drain_ptr <= 1'b0;
      r_col_cnt   <= '0;
      r_row_cnt   <= '0;
      r_full      <= '0;
    end else begin
      if (w_cap) begin
        if (r_col_cnt == '0) begin
          r_col_lim[r_fill_ptr] <= w_cols_in;
          r_row_lim[r_fill_ptr] <= w_rows_in;
        end
        if (w_cap_last) begin
          r_col_cnt  <= '0;
          r_fill_ptr <= ~r_fill_ptr;
        end else begin
          r_col_cnt <= r_col_cnt + 1'b1;
        end
      end
      if (w_hs) r_row_cnt <= w_drain_last ? '0 : r_row_cnt + 1'b1;
      r_full      <= w_full_nxt;
      r_drain_ptr <= w_drain_ptr_nxt;
      // Look at next-cycle flags so a tile completing this edge drains next cycle.
      case (r_state)
        IDLE: begin
          if (w_full_nxt[r_drain_ptr]) begin
            r_state   <= DRAIN;
            r_z_valid <= 1'b1;
          end
        end
        DRAIN: begin
          if (w_drain_last && !w_full_nxt[w_drain_ptr_nxt]) begin
            r_state   <= IDLE;
            r_z_valid <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_z_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_cap && !clear_i) begin
      for (int w = 0; w < int'(Width); w++) begin
        r_bank[r_fill_ptr][w][r_col_cnt] <= z_i[w];
      end
    end
  end

  always_comb begin
    z_o = '0;
    if (r_z_valid) begin
      for (int c = 0; c < int'(COLS); c++) begin
        if (CLW'(c) < r_col_lim[r_drain_ptr]) begin
          z_o[c*BITW +: BITW] = r_bank[r_drain_ptr][r_row_cnt][c];
        end
      end
    end
  end

`ifdef REDMULE_ZBUF_STRB_EN
  logic [15:0] w_strb_bits;
  assign w_strb_bits = 16'(r_col_lim[r_drain_ptr]) * 16'(BITW);

  always_comb begin
    z_strb_o = '0;
    if (r_z_valid) begin
      for (int b = 0; b < int'(DW/8); b++) begin
        if (16'(b*8) < w_strb_bits) z_strb_o[b] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_redmule_z_drain_buffer.sv
// Directed bench for the Z drain buffer: full tiles, leftovers, back-pressure, overlap,
// soft clear and async reset. Element (tile t, row w, col c) carries t*4096 + w*256 + c.
module tb_redmule_z_drain_buffer;

  localparam int DW   = 288;
  localparam int BITW = 16;
  localparam int W    = 12;
  localparam int COLS = DW / BITW;
  localparam int CLW  = $clog2(COLS) + 1;
  localparam int RLW  = $clog2(W) + 1;

  logic                     clk_i = 1'b0;
  logic                     rst_ni;
  logic                     clear_i;
  logic [W-1:0][BITW-1:0]   z_i;
  logic                     z_valid_i;
  logic                     z_ready_o;
  logic [CLW-1:0]           cols_lftovr_i;
  logic [RLW-1:0]           rows_lftovr_i;
  logic [DW-1:0]            z_o;
  logic                     z_valid_o;
  logic                     z_ready_i;
  logic                     full_o;
  logic                     empty_o;
`ifdef REDMULE_ZBUF_STRB_EN
  logic [DW/8-1:0]          z_strb_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  redmule_z_drain_buffer #(.DW(DW), .BITW(BITW), .Width(W)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (clear_i),
    .z_i           (z_i),
    .z_valid_i     (z_valid_i),
    .z_ready_o     (z_ready_o),
    .cols_lftovr_i (cols_lftovr_i),
    .rows_lftovr_i (rows_lftovr_i),
    .z_o           (z_o),
    .z_valid_o     (z_valid_o),
    .z_ready_i     (z_ready_i),
`ifdef REDMULE_ZBUF_STRB_EN
    .z_strb_o      (z_strb_o),
`endif
    .full_o        (full_o),
    .empty_o       (empty_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [BITW-1:0] elem(input int t, input int w, input int c);
    return BITW'(t*4096 + w*256 + c);
  endfunction

  function automatic logic [DW-1:0] exp_word(input int t, input int r, input int nc);
    logic [DW-1:0] v;
    v = '0;
    for (int c = 0; c < nc; c++) v[c*BITW +: BITW] = elem(t, r, c);
    return v;
  endfunction

  function automatic logic [DW/8-1:0] strb_exp(input int nc);
    logic [DW/8-1:0] s;
    s = '0;
    for (int b = 0; b < DW/8; b++) if (b*8 < nc*BITW) s[b] = 1'b1;
    return s;
  endfunction

  task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_idle_state(input string tag);
    chk1({tag, "_valid"}, z_valid_o, 1'b0);
    chk1({tag, "_ready"}, z_ready_o, 1'b1);
    chk1({tag, "_full"},  full_o,    1'b0);
    chk1({tag, "_empty"}, empty_o,   1'b1);
    chkw({tag, "_zo"},    z_o,       '0);
  endtask

  // Drives ncols captures of tile t starting at a negedge; returns at a negedge.
  task automatic capture_tile(input int t, input int ncols, input int cl, input int rl,
                              input bit chk_lat);
    for (int c = 0; c < ncols; c++) begin
      for (int w = 0; w < W; w++) z_i[w] = elem(t, w, c);
      z_valid_i     = 1'b1;
      cols_lftovr_i = CLW'(cl);
      rows_lftovr_i = RLW'(rl);
      chk1("cap_ready", z_ready_o, 1'b1);
      if (chk_lat && c == ncols - 1) chk1("lat_before", z_valid_o, 1'b0);
      @(negedge clk_i);
    end
    z_valid_i = 1'b0;
    if (chk_lat) chk1("lat_after", z_valid_o, 1'b1);
  endtask

  // Consumes nrows words of tile t; toggle alternates z_ready_i 1/0.
  task automatic drain(input int t, input int nrows, input int nc, input bit toggle);
    int  row;
    int  cyc;
    bit  hs;
    row = 0;
    cyc = 0;
    while (row < nrows && cyc < 400) begin
      z_ready_i = toggle ? (cyc % 2 == 0) : 1'b1;
      hs = z_valid_o & z_ready_i;
      if (z_valid_o) begin
        chkw("drain_zo", z_o, exp_word(t, row, nc));
`ifdef REDMULE_ZBUF_STRB_EN
        chkw("drain_strb", DW'(z_strb_o), DW'(strb_exp(nc)));
`endif
      end
      @(negedge clk_i);
      if (hs) row++;
      cyc++;
    end
    z_ready_i = 1'b0;
    n_checks++;
    assert (row == nrows) else begin
      n_errors++;
      $error("FAIL drain_timeout: observed %0d rows expected %0d", row, nrows);
    end
  endtask

  initial begin
    rst_ni        = 1'b0;
    clear_i       = 1'b0;
    z_i           = '0;
    z_valid_i     = 1'b0;
    cols_lftovr_i = '0;
    rows_lftovr_i = '0;
    z_ready_i     = 1'b0;
    #1;
    check_idle_state("reset");
`ifdef REDMULE_ZBUF_STRB_EN
    chkw("reset_strb", DW'(z_strb_o), '0);
`endif
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Full tile with default limits and first-valid latency.
    capture_tile(1, COLS, 0, 0, 1'b1);
    drain(1, W, COLS, 1'b0);
    chk1("t1_done_valid", z_valid_o, 1'b0);
    chk1("t1_done_empty", empty_o, 1'b1);
`ifdef REDMULE_ZBUF_STRB_EN
    chkw("t1_idle_strb", DW'(z_strb_o), '0);
`endif

    // Leftovers: 5 columns, 3 rows; then the 1x1 corner.
    capture_tile(10, 5, 5, 3, 1'b1);
    drain(10, 3, 5, 1'b0);
    capture_tile(11, 1, 1, 1, 1'b1);
    drain(11, 1, 1, 1'b0);
    chk1("lo_done_empty", empty_o, 1'b1);

    // Back-pressure: two tiles held, third capture ignored, stalled word stable.
    capture_tile(2, COLS, 0, 0, 1'b0);
    chk1("bp_one_full", full_o, 1'b0);
    capture_tile(3, COLS, 0, 0, 1'b0);
    chk1("bp_full", full_o, 1'b1);
    chk1("bp_ready", z_ready_o, 1'b0);
    chk1("bp_empty", empty_o, 1'b0);
    for (int w = 0; w < W; w++) z_i[w] = elem(15, w, 0);
    z_valid_i = 1'b1;
    @(negedge clk_i);
    z_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk1("stall_valid", z_valid_o, 1'b1);
      chkw("stall_zo", z_o, exp_word(2, 0, COLS));
      @(negedge clk_i);
    end
    drain(2, W, COLS, 1'b0);
    chk1("bp_next_valid", z_valid_o, 1'b1);
    drain(3, W, COLS, 1'b0);
    chk1("bp_done_empty", empty_o, 1'b1);

    // Overlap: tile 5 captured while tile 4 drains with toggling ready.
    capture_tile(4, COLS, 0, 0, 1'b0);
    fork
      capture_tile(5, COLS, 0, 0, 1'b0);
      drain(4, W, COLS, 1'b1);
    join
    chk1("ov_next_valid", z_valid_o, 1'b1);
    chkw("ov_next_zo", z_o, exp_word(5, 0, COLS));
    drain(5, W, COLS, 1'b0);
    chk1("ov_done_empty", empty_o, 1'b1);

    // Soft clear mid-drain (row 4) with the other bank mid-fill (col 7).
    capture_tile(6, COLS, 0, 0, 1'b0);
    capture_tile(7, 7, 0, 0, 1'b0);
    drain(6, 4, COLS, 1'b0);
    chk1("clr_pre_valid", z_valid_o, 1'b1);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    check_idle_state("clear");
    capture_tile(8, COLS, 0, 0, 1'b1);
    drain(8, W, COLS, 1'b0);

    // Async reset pulse mid-drain; recovery with explicit full-size limits.
    capture_tile(9, COLS, 0, 0, 1'b0);
    drain(9, 2, COLS, 1'b0);
    #3;
    rst_ni = 1'b0;
    #1;
    check_idle_state("async_rst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    capture_tile(12, COLS, COLS, W, 1'b1);
    drain(12, W, COLS, 1'b0);
    chk1("final_empty", empty_o, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
